// File: rtl/ofs_plat_axi_mem_sink_ram_if.sv
// AXI memory interface bundle: aw/w/b/ar/r channels with valid/ready.
// Ports: clk, reset_n (unused by the sink); modports to_source, to_sink.
interface ofs_plat_axi_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic clk;
    logic reset_n;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [USER_WIDTH-1:0] user;
    } t_axi_aw;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } t_axi_ar;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } t_axi_w;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
    } t_axi_b;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } t_axi_r;

    logic    awvalid;
    logic    awready;
    t_axi_aw aw;
    logic    wvalid;
    logic    wready;
    t_axi_w  w;
    logic    bvalid;
    logic    bready;
    t_axi_b  b;
    logic    arvalid;
    logic    arready;
    t_axi_ar ar;
    logic    rvalid;
    logic    rready;
    t_axi_r  r;

    modport to_source (
        input  clk, reset_n,
        input  awvalid, aw, wvalid, w, bready, arvalid, ar, rready,
        output awready, wready, bvalid, b, arready, rvalid, r
    );

    modport to_sink (
        input  clk, reset_n,
        output awvalid, aw, wvalid, w, bready, arvalid, ar, rready,
        input  awready, wready, bvalid, b, arready, rvalid, r
    );
endinterface

// File: rtl/ofs_plat_axi_mem_sink_ram.sv
// AXI responder backed by an internal RAM of 2**MEM_DEPTH_LOG2 data lines.
// Ports: clk, reset (sync, active high), mem_source (AXI to_source end).
// Macro OFS_PLAT_AXI_MEM_SINK_RAM_RANGE_CHECK_EN: out-of-range lines -> SLVERR.
module ofs_plat_axi_mem_sink_ram #(
    parameter int MEM_DEPTH_LOG2   = 10,
    parameter int RD_FIRST_LATENCY = 1
) (
    input logic                   clk,
    input logic                   reset,
    ofs_plat_axi_mem_if.to_source mem_source
);
    localparam int AW    = $bits(mem_source.aw.addr);
    localparam int DW    = $bits(mem_source.w.data);
    localparam int BYTES = DW / 8;
    localparam int BB    = $clog2(BYTES);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int IW    = $bits(mem_source.aw.id);
    localparam int UW    = $bits(mem_source.aw.user);
`ifdef OFS_PLAT_AXI_MEM_SINK_RAM_RANGE_CHECK_EN
    // Keep the full line index so overflow past the RAM is visible.
    localparam int LW    = AW - BB;
`else
    localparam int LW    = MEM_DEPTH_LOG2;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return LW'(a >> BB);
    endfunction

    // Constant false when only the in-range bits are kept.
    function automatic logic oob(input logic [LW-1:0] l);
        return {1'b0, l} >= (LW+1)'(DEPTH);
    endfunction

    logic [DW-1:0] mem [DEPTH];

    w_state_t      w_state, w_next;
    logic [IW-1:0] w_id;
    logic [UW-1:0] w_user;
    logic [7:0]    w_len, w_cnt;
    logic [LW-1:0] w_line;
    logic          w_err, w_drop;

    r_state_t      r_state, r_next;
    logic [IW-1:0] r_id;
    logic [UW-1:0] r_user;
    logic [7:0]    r_len, r_cnt;
    logic [LW-1:0] r_line, ar_line;
    logic [DW-1:0] r_data;
    logic          r_oob;

    logic aw_hs, w_hs, ar_hs, r_hs, r_last, w_beat_last;

    assign mem_source.awready = (w_state == W_IDLE) && !reset;
    assign mem_source.wready  = (w_state == W_DATA) && !reset;
    assign mem_source.bvalid  = (w_state == W_RESP) && !reset;
    assign mem_source.arready = (r_state == R_IDLE) && !reset;
    assign mem_source.rvalid  = (r_state == R_DATA) && !reset;

    assign aw_hs = mem_source.awvalid && mem_source.awready;
    assign w_hs  = mem_source.wvalid && mem_source.wready;
    assign ar_hs = mem_source.arvalid && mem_source.arready;
    assign r_hs  = mem_source.rvalid && mem_source.rready;

    assign w_beat_last = (w_cnt == w_len);
    assign r_last      = (r_cnt == r_len);
    assign ar_line     = line_of(mem_source.ar.addr);

    assign mem_source.b.id   = w_id;
    assign mem_source.b.resp = w_err ? 2'b10 : 2'b00;
    assign mem_source.b.user = w_user;

    assign mem_source.r.id   = r_id;
    assign mem_source.r.data = r_data;
    assign mem_source.r.resp = r_oob ? 2'b10 : 2'b00;
    assign mem_source.r.user = r_user;
    assign mem_source.r.last = r_last;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_beat_last) w_next = W_RESP;
            W_RESP:  if (mem_source.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_user  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_line  <= '0;
            w_err   <= 1'b0;
            w_drop  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id   <= mem_source.aw.id;
                w_user <= mem_source.aw.user;
                w_len  <= mem_source.aw.len;
                w_cnt  <= '0;
                w_line <= line_of(mem_source.aw.addr);
                // Atomics are not supported: swallow data, report SLVERR.
                w_err  <= (mem_source.aw.atop != '0);
                w_drop <= (mem_source.aw.atop != '0);
            end
            if (w_hs) begin
                w_cnt  <= w_cnt + 8'd1;
                w_line <= w_line + LW'(1);
                if (oob(w_line) || (mem_source.w.last != w_beat_last))
                    w_err <= 1'b1;
            end
        end
    end

    // RAM is never reset; wready is already gated by reset.
    always_ff @(posedge clk) begin
        if (w_hs && !w_drop && !oob(w_line)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (mem_source.w.strb[i])
                    mem[w_line[MEM_DEPTH_LOG2-1:0]][i*8 +: 8] <=
                        mem_source.w.data[i*8 +: 8];
            end
        end
    end

    // Loads read mem before any same-cycle write lands (old data wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_user  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_line  <= '0;
            r_data  <= '0;
            r_oob   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id   <= mem_source.ar.id;
                r_user <= mem_source.ar.user;
                r_len  <= mem_source.ar.len;
                r_cnt  <= '0;
                r_line <= ar_line + LW'(1);
                r_oob  <= oob(ar_line);
                r_data <= oob(ar_line) ? '0 :
                          mem[ar_line[MEM_DEPTH_LOG2-1:0]];
            end else if (r_hs && !r_last) begin
                r_cnt  <= r_cnt + 8'd1;
                r_line <= r_line + LW'(1);
                r_oob  <= oob(r_line);
                r_data <= oob(r_line) ? '0 :
                          mem[r_line[MEM_DEPTH_LOG2-1:0]];
            end
        end
    end

    logic unused;
    assign unused = RD_FIRST_LATENCY[0];
endmodule

// File: tb/tb_ofs_plat_axi_mem_sink_ram.sv
// Directed bench for ofs_plat_axi_mem_sink_ram (64-bit data, 16 lines).
// Ports: drives the AXI to_source end through an interface instance.
module tb_ofs_plat_axi_mem_sink_ram;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ofs_plat_axi_mem_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(8)
    ) axi ();

    assign axi.clk = clk;
    assign axi.reset_n = ~reset;

    ofs_plat_axi_mem_sink_ram #(.MEM_DEPTH_LOG2(4)) dut (
        .clk(clk),
        .reset(reset),
        .mem_source(axi.to_source)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_d  [8];
    logic [1:0]  exp_rs [8];

`ifdef OFS_PLAT_AXI_MEM_SINK_RAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] len,
                           input logic [3:0] id, input logic [7:0] user,
                           input logic [5:0] atop);
        int n = 0;
        @(negedge clk);
        axi.aw = '0;
        axi.aw.addr = a;
        axi.aw.len = len;
        axi.aw.id = id;
        axi.aw.user = user;
        axi.aw.atop = atop;
        axi.awvalid = 1'b1;
        while (!axi.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("aw_ready", axi.awready, 1);
        @(posedge clk);
        #1 axi.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] strb,
                          input logic last);
        int n = 0;
        @(negedge clk);
        axi.w = '0;
        axi.w.data = d;
        axi.w.strb = strb;
        axi.w.last = last;
        axi.wvalid = 1'b1;
        while (!axi.wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w_ready", axi.wready, 1);
        @(posedge clk);
        #1 axi.wvalid = 1'b0;
    endtask

    task automatic b_chk(input logic [3:0] id, input logic [7:0] user,
                         input logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        axi.bready = 1'b1;
        while (!axi.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_valid", axi.bvalid, 1);
        chk("b_id", axi.b.id, id);
        chk("b_user", axi.b.user, user);
        chk("b_resp", axi.b.resp, resp);
        @(posedge clk);
        #1 axi.bready = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [63:0] d);
        aw_send(a, 8'd0, 4'd0, 8'd0, 6'd0);
        w_send(d, 8'hFF, 1'b1);
        b_chk(4'd0, 8'd0, 2'b00);
    endtask

    task automatic rd(input logic [31:0] a, input int len,
                      input logic [3:0] id, input bit tog);
        int beat = 0;
        int cyc = 0;
        @(negedge clk);
        axi.ar = '0;
        axi.ar.addr = a;
        axi.ar.len = 8'(len);
        axi.ar.id = id;
        axi.arvalid = 1'b1;
        chk("ar_ready", axi.arready, 1);
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        @(negedge clk);
        while (beat <= len && cyc < 100) begin
            axi.rready = tog ? (cyc % 3 == 0) : 1'b1;
            chk("r_valid", axi.rvalid, 1);
            chk("r_data", axi.r.data, exp_d[beat]);
            chk("r_last", axi.r.last, beat == len);
            chk("r_id", axi.r.id, id);
            chk("r_resp", axi.r.resp, exp_rs[beat]);
            if (axi.rvalid && axi.rready) beat++;
            @(negedge clk);
            cyc++;
        end
        axi.rready = 1'b0;
        chk("r_beats", beat, len + 1);
        chk("r_idle", axi.rvalid, 0);
    endtask

    initial begin
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        axi.aw = '0;
        axi.w = '0;
        axi.ar = '0;
        foreach (exp_rs[i]) exp_rs[i] = 2'b00;
        foreach (exp_d[i]) exp_d[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_awready", axi.awready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        reset = 1'b0;
        #1;
        chk("post_awready", axi.awready, 1);
        chk("post_arready", axi.arready, 1);

        aw_send(32'h10, 8'd3, 4'd5, 8'hA1, 6'd0);
        w_send(64'h11, 8'hFF, 1'b0);
        w_send(64'h22, 8'hFF, 1'b0);
        w_send(64'h33, 8'hFF, 1'b0);
        w_send(64'h44, 8'hFF, 1'b1);
        b_chk(4'd5, 8'hA1, 2'b00);

        exp_d[0] = 64'h11;
        exp_d[1] = 64'h22;
        exp_d[2] = 64'h33;
        exp_d[3] = 64'h44;
        rd(32'h10, 3, 4'd7, 1'b0);
        rd(32'h10, 3, 4'd7, 1'b1);

        aw_send(32'h40, 8'd1, 4'd1, 8'h00, 6'd0);
        w_send(64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 1'b0);
        w_send(64'h1111_1111_1111_1111, 8'hFF, 1'b1);
        b_chk(4'd1, 8'h00, 2'b00);
        aw_send(32'h40, 8'd1, 4'd2, 8'h5A, 6'd0);
        w_send(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1);
        w_send(64'hBBBB_BBBB_BBBB_BBBB, 8'h0F, 1'b1);
        b_chk(4'd2, 8'h5A, 2'b10);
        exp_d[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        exp_d[1] = 64'h1111_1111_BBBB_BBBB;
        rd(32'h40, 1, 4'd3, 1'b0);

        wr1(32'h60, 64'h1212);
        aw_send(32'h60, 8'd0, 4'd4, 8'h00, 6'h20);
        w_send(64'h9999, 8'hFF, 1'b1);
        b_chk(4'd4, 8'h00, 2'b10);
        exp_d[0] = 64'h1212;
        rd(32'h60, 0, 4'd4, 1'b0);

        wr1(32'h0, 64'h77);
        aw_send(32'h78, 8'd1, 4'd6, 8'h3C, 6'd0);
        w_send(64'h55, 8'hFF, 1'b0);
        w_send(64'h66, 8'hFF, 1'b1);
        b_chk(4'd6, 8'h3C, RC ? 2'b10 : 2'b00);
        exp_d[0] = 64'h55;
        exp_d[1] = RC ? 64'h0 : 64'h66;
        exp_rs[1] = RC ? 2'b10 : 2'b00;
        rd(32'h78, 1, 4'd6, 1'b0);
        exp_rs[1] = 2'b00;
        exp_d[0] = RC ? 64'h77 : 64'h66;
        rd(32'h0, 0, 4'd0, 1'b0);

        @(negedge clk);
        axi.ar = '0;
        axi.ar.addr = 32'h10;
        axi.ar.len = 8'd3;
        axi.ar.id = 4'd9;
        axi.arvalid = 1'b1;
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        @(negedge clk);
        axi.rready = 1'b1;
        chk("mid_b0", axi.r.data, 64'h11);
        @(negedge clk);
        chk("mid_b1", axi.r.data, 64'h22);
        @(negedge clk);
        chk("mid_b2", axi.r.data, 64'h33);
        reset = 1'b1;
        axi.rready = 1'b0;
        #1;
        chk("mid_rst_rvalid", axi.rvalid, 0);
        @(negedge clk);
        chk("mid_rst_rvalid2", axi.rvalid, 0);
        chk("mid_rst_arready", axi.arready, 0);
        chk("mid_rst_awready", axi.awready, 0);
        reset = 1'b0;
        #1;
        chk("rel_awready", axi.awready, 1);
        chk("rel_arready", axi.arready, 1);
        chk("rel_rvalid", axi.rvalid, 0);
        exp_d[0] = 64'h11;
        exp_d[1] = 64'h22;
        exp_d[2] = 64'h33;
        exp_d[3] = 64'h44;
        rd(32'h10, 3, 4'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofs_plat_axi_mem_sink_ram.md
OFS_PLAT_AXI_MEM_SINK_RAM -- requirements
Module: ofs_plat_axi_mem_sink_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of the number of data lines in the internal RAM.
REQ-002 SHALL have parameter RD_FIRST_LATENCY, default 1, fixed at 1: cycles from AR handshake to first rvalid; documentation only.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_source  ofs_plat_axi_mem_if.to_source  per-interface  AXI responder end: aw, w, ar inputs; b, r outputs. Widths come from the interface parameters; the interface clk and reset_n are not used.

Function
REQ-006 SHALL derive the line index from addr >> log2(DATA_WIDTH/8), using the low MEM_DEPTH_LOG2 bits.
REQ-007 SHALL treat every beat as a full data line: size, burst, lock, cache, prot, qos and region are ignored, and all bursts are INCR.
REQ-008 SHALL run independent write and read FSMs so that reads and writes proceed concurrently.
REQ-009 Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
- awready=1 only in W_IDLE.
- On the AW handshake, capture id, line index, len and user.
REQ-010 In W_DATA the block SHALL drive wready=1.
- Each W handshake writes each byte with its strb bit set to the current line, then increments the line index, wrapping at the RAM depth.
REQ-011 W_DATA SHALL exit to W_RESP on the handshake of beat number len, whatever the value of w.last.
- A w.last value that disagrees with the beat count sets the pending resp to SLVERR (2'b10).
REQ-012 In W_RESP the block SHALL drive bvalid=1 with b.id=aw.id and b.user=aw.user.
- resp is OKAY (2'b00) unless an error was flagged.
- b is held stable until bready; the FSM returns to W_IDLE the cycle after the handshake.
REQ-013 If aw.atop is nonzero, the block SHALL accept and discard all len+1 data beats without writing, and respond SLVERR.
REQ-014 Read FSM SHALL be R_IDLE -> R_DATA -> R_IDLE:
- arready=1 only in R_IDLE.
- On the AR handshake, capture id, line index, len and user.
- Load the output register from RAM at that line.
REQ-015 In R_DATA the block SHALL drive rvalid=1 beginning the cycle after the AR handshake.
- r.id=ar.id, r.user=ar.user, r.resp=OKAY.
- r.last=1 on beat number len.
- r is held stable while rready is low.
REQ-016 On each R handshake that is not the last, the block SHALL load the next line into r.data so that a beat completes every cycle while rready stays high; after the last handshake the FSM returns to R_IDLE.
REQ-017 When a read register load and a write to the same line share a cycle, the load SHALL return the pre-write contents.
REQ-018 Bursts whose line index passes the RAM depth SHALL wrap modulo the depth, subject to REQ-026.

Reset
REQ-019 While reset=1, the block SHALL drive awready=0, wready=0, bvalid=0, arready=0 and rvalid=0, with both FSMs in IDLE.
REQ-020 After reset deasserts, awready and arready SHALL be 1 on the first cycle.
REQ-021 RAM contents SHALL NOT be reset.
REQ-022 Reset mid-burst SHALL abandon the burst with no b or r response issued, keeping any beats already written.
REQ-023 All captured registers (id, user, len, index, error flag, r.data) SHALL reset to 0.

Configuration
REQ-024 SHALL support macro OFS_PLAT_AXI_MEM_SINK_RAM_RANGE_CHECK_EN.
REQ-025 Without the macro, address bits above the line index SHALL be ignored and every in-protocol access SHALL return OKAY.
REQ-026 With the macro:
- Any beat whose full line index (addr >> byte bits, before truncation) is >= 2**MEM_DEPTH_LOG2 SHALL be dropped on write, return r.data=0 on read, and make the response SLVERR.
- The SLVERR is on b for writes, or on that beat's r.resp for reads.
- Wrap (REQ-018) does not occur.

Verification (DATA_WIDTH=64, MEM_DEPTH_LOG2=4)
REQ-027 AW addr 0x10 len 3 id 5 user 0xA1, four W beats 0x11..0x44 strb 0xFF, last on beat 3 -> a single b with id 5, user 0xA1, resp 2'b00; mem[2..5] hold 0x11..0x44.
REQ-028 AR addr 0x10 len 3 id 7 with rready=1 -> rvalid the cycle after the handshake, four consecutive beats 0x11..0x44, r.last only on beat 3, id 7.
REQ-029 The same read with rready toggling 1,0,0,1,... -> r held stable during the stalls; no beat lost or duplicated.
REQ-030 Write len 1 with w.last on beat 0 -> b.resp=2'b10 after beat 1; strb 0x0F on a beat updates only the low 4 bytes.
REQ-031 AW addr 0x78 len 1: without the macro -> lines 15 and 0 written, resp OKAY; with the macro -> line 15 written, beat 1 dropped, resp 2'b10.
REQ-032 Assert reset during beat 2 of a len 3 read, then issue a new AR -> no stale rvalid; awready=arready=1 on the first cycle after reset; the new burst returns correct data.
